// File: rtl/timer_apb_slave.sv
// -----------------------------------------------------------------------------
// timer_apb_slave
//   APB register block for a simple 8-bit timer. It holds the timer's
//   configuration (TDR, TCR, TIER) and sticky status (TSR), reads back the live
//   counter value, and raises a registered interrupt request.
//
//   Register map:
//     0x00 TDR  (RW)    reload / compare data
//     0x01 TCR  (RW)    [7] load, [5] updw, [4] en, [1:0] cks; other bits 0
//     0x02 TSR  (RW0C)  [0] OVF, [1] UDF; set by hardware, cleared by writing 0
//     0x03 TCNT (RO)    live tcnt input; writes ignored without error
//     0x04 TIER (RW)    [0] OVF interrupt enable, [1] UDF interrupt enable
//     other addresses   pslverr=1, prdata=0x00, no register changes
//
//   Ports:
//     pclk, preset                    clock, synchronous active-high reset
//     psel, penable, pwrite,
//     paddr[7:0], pwdata[7:0]         APB requester signals
//     prdata[7:0], pready, pslverr    APB responder signals
//     tdr[7:0], tcr_load, tcr_updw,
//     tcr_en, tcr_cks[1:0]            configuration to the timer core
//     tcnt[7:0]                       live counter value from the timer core
//     ovf_set, udf_set                one-cycle status set pulses
//     tmr_int                         registered interrupt request
//
//   Build option:
//     TIMER_APB_WAIT_EN  defined   -> one wait state per transfer
//                        undefined -> zero wait states (default)
// -----------------------------------------------------------------------------
module timer_apb_slave (
  input  logic       pclk,
  input  logic       preset,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  output logic [7:0] tdr,
  output logic       tcr_load,
  output logic       tcr_updw,
  output logic       tcr_en,
  output logic [1:0] tcr_cks,
  input  logic [7:0] tcnt,
  input  logic       ovf_set,
  input  logic       udf_set,
  output logic       tmr_int
);

  localparam logic [7:0] ADDR_TDR  = 8'h00;
  localparam logic [7:0] ADDR_TCR  = 8'h01;
  localparam logic [7:0] ADDR_TSR  = 8'h02;
  localparam logic [7:0] ADDR_TCNT = 8'h03;
  localparam logic [7:0] ADDR_TIER = 8'h04;

  // Writable TCR bits: load, updw, en, cks.
  localparam logic [7:0] TCR_MASK  = 8'hB3;

  // state_q records which phase the previous cycle was in:
  //   IDLE   - no transfer open
  //   SETUP  - previous cycle was the APB setup phase
  //   ACCESS - previous cycle was an access cycle that inserted a wait state
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t     state_q;
  logic [7:0] tdr_q;
  logic [7:0] tcr_q;
  logic [1:0] tsr_q;
  logic [1:0] tier_q;
  logic       tmr_int_q;

  logic       ready_cyc;
  logic       complete;
  logic       addr_ok;
  logic       wr_en;
  logic       wr_tsr;
  logic [7:0] rd_mux;

`ifdef TIMER_APB_WAIT_EN
  // The first access cycle after setup is a wait state; the second completes.
  assign ready_cyc = psel & penable & (state_q == ACCESS);
`else
  // The first access cycle after setup completes.
  assign ready_cyc = psel & penable & (state_q == SETUP);
`endif

  // Reset wins over a transfer in flight: nothing completes while preset=1.
  assign complete = ready_cyc & ~preset;
  assign addr_ok  = (paddr <= ADDR_TIER);
  assign wr_en    = complete & pwrite & addr_ok;
  assign wr_tsr   = wr_en & (paddr == ADDR_TSR);

  // NOTE: every variable assigned in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_mux = 8'h00;
    case (paddr)
      ADDR_TDR:  rd_mux = tdr_q;
      ADDR_TCR:  rd_mux = tcr_q;
      ADDR_TSR:  rd_mux = {6'b0, tsr_q};
      ADDR_TCNT: rd_mux = tcnt;
      ADDR_TIER: rd_mux = {6'b0, tier_q};
      default:   rd_mux = 8'h00;
    endcase
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the values from before the edge, regardless of order.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      tdr_q     <= 8'h00;
      tcr_q     <= 8'h00;
      tsr_q     <= 2'b00;
      tier_q    <= 2'b00;
      tmr_int_q <= 1'b0;
    end else begin
      // Transfer tracking; dropping psel always abandons the transfer.
      if (!psel)
        state_q <= IDLE;
      else if (!penable)
        state_q <= SETUP;
      else if (complete || state_q == IDLE)
        state_q <= IDLE;
      else
        state_q <= ACCESS;

      if (wr_en && paddr == ADDR_TDR)  tdr_q  <= pwdata;
      if (wr_en && paddr == ADDR_TCR)  tcr_q  <= pwdata & TCR_MASK;
      if (wr_en && paddr == ADDR_TIER) tier_q <= pwdata[1:0];

      // Sticky status: a hardware set in the same cycle beats a software clear.
      tsr_q[0] <= ovf_set | (tsr_q[0] & ~(wr_tsr & ~pwdata[0]));
      tsr_q[1] <= udf_set | (tsr_q[1] & ~(wr_tsr & ~pwdata[1]));

      tmr_int_q <= |(tsr_q & tier_q);
    end
  end

  // Outputs are held at zero for the whole time preset is high, including the
  // first reset cycle before the registers have been cleared.
  assign pready   = complete;
  assign pslverr  = complete & ~addr_ok;
  assign prdata   = complete ? rd_mux : 8'h00;

  assign tdr      = preset ? 8'h00 : tdr_q;
  assign tcr_load = ~preset & tcr_q[7];
  assign tcr_updw = ~preset & tcr_q[5];
  assign tcr_en   = ~preset & tcr_q[4];
  assign tcr_cks  = preset ? 2'b00 : tcr_q[1:0];
  assign tmr_int  = ~preset & tmr_int_q;

endmodule

// File: tb/tb_timer_apb_slave.sv
// -----------------------------------------------------------------------------
// tb_timer_apb_slave
//   Self-checking bench for timer_apb_slave. A register-level model (plain
//   bytes updated by the register rules) predicts read data, errors, timer
//   outputs and the interrupt line for directed and randomized traffic.
// -----------------------------------------------------------------------------
module tb_timer_apb_slave;

`ifdef TIMER_APB_WAIT_EN
  localparam int WAITS = 1;
`else
  localparam int WAITS = 0;
`endif

  logic       pclk = 1'b0;
  logic       preset = 1'b1;
  logic       psel = 1'b0;
  logic       penable = 1'b0;
  logic       pwrite = 1'b0;
  logic [7:0] paddr = 8'h00;
  logic [7:0] pwdata = 8'h00;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;
  logic [7:0] tdr;
  logic       tcr_load;
  logic       tcr_updw;
  logic       tcr_en;
  logic [1:0] tcr_cks;
  logic [7:0] tcnt = 8'h00;
  logic       ovf_set = 1'b0;
  logic       udf_set = 1'b0;
  logic       tmr_int;

  int tests = 0;
  int fails = 0;

  // Reference register state.
  logic [7:0] m_tdr, m_tcr, m_tsr, m_tier;

  timer_apb_slave dut (
    .pclk     (pclk),
    .preset   (preset),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr),
    .tdr      (tdr),
    .tcr_load (tcr_load),
    .tcr_updw (tcr_updw),
    .tcr_en   (tcr_en),
    .tcr_cks  (tcr_cks),
    .tcnt     (tcnt),
    .ovf_set  (ovf_set),
    .udf_set  (udf_set),
    .tmr_int  (tmr_int)
  );

  always #5 pclk = ~pclk;

  // ---------------------------------------------------------------- model
  function automatic logic [7:0] model_read(input logic [7:0] a);
    case (a)
      8'h00:   return m_tdr;
      8'h01:   return m_tcr;
      8'h02:   return m_tsr;
      8'h03:   return tcnt;
      8'h04:   return m_tier;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic model_int();
    return (m_tsr[0] & m_tier[0]) | (m_tsr[1] & m_tier[1]);
  endfunction

  task automatic model_reset();
    m_tdr = 8'h00; m_tcr = 8'h00; m_tsr = 8'h00; m_tier = 8'h00;
  endtask

  // --------------------------------------------------------- bus transfer
  // One APB transfer. hw is driven onto {udf_set, ovf_set} during the
  // completing cycle so hardware sets can land on the write edge.
  task automatic apb_xfer(input logic wr, input logic [7:0] a, input logic [7:0] d,
                          input logic [1:0] hw, output logic [7:0] rd, output logic err);
    int  waits;
    logic done;
    waits = 0; done = 1'b0; rd = 8'h00; err = 1'b0;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge pclk); #1;
    penable = 1'b1;
    for (int i = 0; i < 8 && !done; i++) begin
      #3;
      if (pready) begin
        rd = prdata; err = pslverr; done = 1'b1;
        {udf_set, ovf_set} = hw;
      end else begin
        waits++;
      end
      @(posedge pclk); #1;
    end
    psel = 1'b0; penable = 1'b0; {udf_set, ovf_set} = 2'b00;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL xfer_timeout addr=%02h: pready never seen in 8 cycles", a);
    end else if (waits != WAITS) begin
      fails++;
      $display("FAIL wait_states addr=%02h: got %0d want %0d", a, waits, WAITS);
    end
  endtask

  task automatic check_timer_outputs(input string tag);
    tests++;
    if ({tdr, tcr_load, tcr_updw, tcr_en, tcr_cks} !==
        {m_tdr, m_tcr[7], m_tcr[5], m_tcr[4], m_tcr[1:0]}) begin
      fails++;
      $display("FAIL %s outputs: tdr=%02h ld=%b ud=%b en=%b cks=%b want tdr=%02h tcr=%02h",
               tag, tdr, tcr_load, tcr_updw, tcr_en, tcr_cks, m_tdr, m_tcr);
    end
  endtask

  // Transfer plus model update and comparison of response and side effects.
  task automatic do_op(input logic wr, input logic [7:0] a, input logic [7:0] d,
                       input logic [1:0] hw, output logic [7:0] rd);
    logic [7:0] exp_rd;
    logic       exp_err;
    logic       err;
    exp_rd  = model_read(a);
    exp_err = (a > 8'h04);
    apb_xfer(wr, a, d, hw, rd, err);
    if (wr && !exp_err) begin
      case (a)
        8'h00: m_tdr  = d;
        8'h01: m_tcr  = d & 8'hB3;
        8'h02: m_tsr  = m_tsr & d;
        8'h04: m_tier = d & 8'h03;
        default: ;
      endcase
    end
    m_tsr = m_tsr | {6'b0, hw};
    tests++;
    if (rd !== exp_rd || err !== exp_err) begin
      fails++;
      $display("FAIL op %s addr=%02h: prdata=%02h pslverr=%b want %02h %b",
               wr ? "wr" : "rd", a, rd, err, exp_rd, exp_err);
    end
    check_timer_outputs("op");
    // Interrupt follows status/enable changes one edge later.
    @(posedge pclk); #1;
    tests++;
    if (tmr_int !== model_int()) begin
      fails++;
      $display("FAIL tmr_int after op addr=%02h: got %b want %b", a, tmr_int, model_int());
    end
  endtask

  task automatic pulse_hw(input logic [1:0] hw);
    @(posedge pclk); #1;
    {udf_set, ovf_set} = hw;
    @(posedge pclk); #1;
    {udf_set, ovf_set} = 2'b00;
    m_tsr = m_tsr | {6'b0, hw};
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] got, input logic [7:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %02h want %02h", tag, got, want);
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    logic [7:0] rd;
    preset = 1'b1; ovf_set = 1'b1; udf_set = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    tests++;
    if ({prdata, pready, pslverr, tmr_int, tdr, tcr_load, tcr_updw, tcr_en, tcr_cks} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: prdata=%02h pready=%b pslverr=%b int=%b tdr=%02h",
               prdata, pready, pslverr, tmr_int, tdr);
    end
    preset = 1'b0; ovf_set = 1'b0; udf_set = 1'b0;
    model_reset();
    do_op(1'b0, 8'h00, 8'h00, 2'b00, rd); expect_byte("reset_tdr",  rd, 8'h00);
    do_op(1'b0, 8'h01, 8'h00, 2'b00, rd); expect_byte("reset_tcr",  rd, 8'h00);
    do_op(1'b0, 8'h02, 8'h00, 2'b00, rd); expect_byte("reset_tsr",  rd, 8'h00);
    do_op(1'b0, 8'h04, 8'h00, 2'b00, rd); expect_byte("reset_tier", rd, 8'h00);
  endtask

  task automatic test_tcr();
    logic [7:0] rd;
    do_op(1'b1, 8'h01, 8'hFF, 2'b00, rd);
    do_op(1'b0, 8'h01, 8'h00, 2'b00, rd);
    expect_byte("tcr_readback", rd, 8'hB3);
    tests++;
    if ({tcr_load, tcr_updw, tcr_en, tcr_cks} !== 5'b11111) begin
      fails++;
      $display("FAIL tcr_fields: got %b want 11111", {tcr_load, tcr_updw, tcr_en, tcr_cks});
    end
    do_op(1'b1, 8'h00, 8'h5A, 2'b00, rd);
    expect_byte("tdr_out", tdr, 8'h5A);
  endtask

  task automatic test_sticky();
    logic [7:0] rd;
    do_op(1'b1, 8'h02, 8'h00, 2'b00, rd);
    pulse_hw(2'b01);
    do_op(1'b0, 8'h02, 8'h00, 2'b00, rd); expect_byte("tsr_set",      rd, 8'h01);
    do_op(1'b1, 8'h02, 8'hFF, 2'b00, rd);
    do_op(1'b0, 8'h02, 8'h00, 2'b00, rd); expect_byte("tsr_write1",   rd, 8'h01);
    do_op(1'b1, 8'h02, 8'h00, 2'b00, rd);
    do_op(1'b0, 8'h02, 8'h00, 2'b00, rd); expect_byte("tsr_write0",   rd, 8'h00);
  endtask

  task automatic test_collision();
    logic [7:0] rd;
    pulse_hw(2'b11);
    do_op(1'b1, 8'h02, 8'h00, 2'b10, rd);
    do_op(1'b0, 8'h02, 8'h00, 2'b00, rd); expect_byte("set_beats_clear", rd, 8'h02);
    do_op(1'b1, 8'h02, 8'h00, 2'b00, rd);
  endtask

  task automatic test_interrupt();
    logic [7:0] rd;
    do_op(1'b1, 8'h04, 8'h01, 2'b00, rd);
    pulse_hw(2'b01);
    tests++;
    if (tmr_int !== 1'b0) begin
      fails++;
      $display("FAIL int_latency_rise: got %b want 0 in the set cycle", tmr_int);
    end
    @(posedge pclk); #1;
    tests++;
    if (tmr_int !== 1'b1) begin
      fails++;
      $display("FAIL int_rise: got %b want 1", tmr_int);
    end
    // do_op checks tmr_int one edge after the clearing write.
    do_op(1'b1, 8'h02, 8'h00, 2'b00, rd);
    expect_byte("int_fall", {7'b0, tmr_int}, 8'h00);
    // Masked source must not interrupt.
    pulse_hw(2'b10);
    @(posedge pclk); #1;
    expect_byte("int_masked", {7'b0, tmr_int}, 8'h00);
    do_op(1'b1, 8'h02, 8'h00, 2'b00, rd);
  endtask

  task automatic test_error();
    logic [7:0] rd;
    do_op(1'b1, 8'h00, 8'hC3, 2'b00, rd);
    do_op(1'b1, 8'h07, 8'h55, 2'b00, rd); expect_byte("err_wr_prdata", rd, 8'h00);
    do_op(1'b0, 8'h07, 8'h00, 2'b00, rd); expect_byte("err_rd_prdata", rd, 8'h00);
    do_op(1'b1, 8'h03, 8'h77, 2'b00, rd);
    do_op(1'b0, 8'h00, 8'h00, 2'b00, rd); expect_byte("err_tdr_kept",  rd, 8'hC3);
    tcnt = 8'h9E;
    do_op(1'b0, 8'h03, 8'h00, 2'b00, rd); expect_byte("tcnt_live",     rd, 8'h9E);
  endtask

  task automatic test_reset_abort();
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h3C;
    @(posedge pclk); #1;
    penable = 1'b1; preset = 1'b1;
    #3;
    tests++;
    if ({pready, pslverr, prdata, tdr, tcr_en} !== '0) begin
      fails++;
      $display("FAIL abort_outputs: pready=%b pslverr=%b prdata=%02h tdr=%02h",
               pready, pslverr, prdata, tdr);
    end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; preset = 1'b0;
    model_reset();
    check_timer_outputs("abort");
    expect_byte("abort_tdr", tdr, 8'h00);
  endtask

  task automatic test_random();
    logic [7:0] a, d, rd;
    logic       wr;
    logic [1:0] hw;
    for (int i = 0; i < 150; i++) begin
      a  = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      wr = 1'($urandom);
      d  = 8'($urandom);
      hw = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      tcnt = 8'($urandom);
      do_op(wr, a, d, hw, rd);
      if ($urandom_range(0, 5) == 0) pulse_hw(2'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd;
    for (int i = 0; i < 5; i++) begin
      do_op(1'b1, 8'(i), 8'($urandom), 2'b00, rd);
      do_op(1'b0, 8'(i), 8'h00, 2'b00, rd);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_tcr();
    test_sticky();
    test_collision();
    test_interrupt();
    test_error();
    test_back_to_back();
    test_random();
    test_reset_abort();
    test_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
